// File: rtl/seg_to_bin.sv
// Recovers the displayed bit from a two-symbol 7-segment bus once the pattern has settled.
// Optional saturating error counter enabled by defining SEG_DEC_ERR_CNT_EN.
module seg_to_bin #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       segment,
    output logic             out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             invalid,
    output logic             overrun,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [6:0] PAT_ZERO  = 7'b1111110;
    localparam logic [6:0] PAT_ONE   = 7'b0110000;
    localparam logic [6:0] PAT_BLANK = 7'b0000000;
    localparam logic [7:0] CNT_LAST  = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_MAX   = 8'(STABLE_CYCLES);

    typedef enum logic {SETTLE, LOCKED} state_t;

    state_t     state, state_n;
    logic [7:0] count, count_n;
    logic [6:0] seg_q;
    logic [6:0] last_pat;
    logic       stable;
    logic       eval;

    assign stable = (segment == seg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
            count <= '0;
            seg_q <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            seg_q <= segment;
        end
    end

    // Evaluation fires on the edge where the count would reach STABLE_CYCLES,
    // so the registered result appears STABLE_CYCLES+1 edges after the change.
    always_comb begin
        state_n = state;
        count_n = count;
        eval    = 1'b0;
        case (state)
            SETTLE: begin
                if (!stable) begin
                    count_n = '0;
                end else if (count == CNT_LAST) begin
                    eval    = 1'b1;
                    count_n = CNT_MAX;
                    state_n = LOCKED;
                end else begin
                    count_n = count + 8'd1;
                end
            end
            LOCKED: begin
                if (!stable) begin
                    count_n = '0;
                    state_n = SETTLE;
                end
            end
            default: begin
                count_n = '0;
                state_n = SETTLE;
            end
        endcase
    end

    logic is_zero, is_one, is_blank, is_legal, novel, load, accept;

    assign is_zero  = (seg_q == PAT_ZERO);
    assign is_one   = (seg_q == PAT_ONE);
    assign is_blank = (seg_q == PAT_BLANK);
    assign is_legal = is_zero | is_one;
    assign novel    = eval && (seg_q != last_pat);
    assign accept   = out_valid && out_ready;
    assign load     = novel && is_legal && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pat  <= PAT_BLANK;
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            invalid   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            invalid <= novel && !is_legal && !is_blank;
            overrun <= novel && is_legal && out_valid && !out_ready;
            if (novel) begin
                last_pat <= seg_q;
            end
            if (load) begin
                out_data  <= is_one;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SEG_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if ((invalid || overrun) && (err_q != {CNT_W{1'b1}})) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_seg_to_bin.sv
// Directed plus random stimulus for seg_to_bin, checked every cycle against a
// run-length based reference model.
module tb_seg_to_bin;

    localparam int S  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    segment = 7'd0;
    logic          out_ready = 1'b0;
    logic          out_data, out_valid, invalid, overrun;
    logic [CW-1:0] err_count;

    int total = 0;
    int bad   = 0;

    // Reference model state: length of the current run of identical samples,
    // counting the reset value of the sample register as the first member.
    logic [6:0] mPrev, mLast;
    int         runLen;
    logic       mValid, mData, mInv, mOvr;
    int         mErr;

    seg_to_bin #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .segment(segment),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .invalid(invalid), .overrun(overrun), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic void resetModel();
        mPrev = 7'd0; mLast = 7'd0; runLen = 1;
        mValid = 1'b0; mData = 1'b0; mInv = 1'b0; mOvr = 1'b0; mErr = 0;
    endfunction

    function automatic void updateModel(input logic [6:0] s, input logic r);
        logic newInv, newOvr, load, legal;
        newInv = 1'b0; newOvr = 1'b0; load = 1'b0;
        legal = (s == 7'b1111110) || (s == 7'b0110000);
`ifdef SEG_DEC_ERR_CNT_EN
        if ((mInv || mOvr) && mErr < (2**CW - 1)) mErr++;
`endif
        runLen = (s == mPrev) ? runLen + 1 : 1;
        mPrev = s;
        if (runLen == S + 1 && s != mLast) begin
            mLast = s;
            if (legal) begin
                if (!mValid || r) load = 1'b1;
                else newOvr = 1'b1;
            end else if (s != 7'd0) begin
                newInv = 1'b1;
            end
        end
        if (load) begin
            mValid = 1'b1;
            mData = (s == 7'b0110000);
        end else if (mValid && r) begin
            mValid = 1'b0;
        end
        mInv = newInv;
        mOvr = newOvr;
    endfunction

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, ".out_valid"}, 32'(out_valid), 32'(mValid));
        checkOne({tag, ".out_data"},  32'(out_data),  32'(mData));
        checkOne({tag, ".invalid"},   32'(invalid),   32'(mInv));
        checkOne({tag, ".overrun"},   32'(overrun),   32'(mOvr));
        checkOne({tag, ".err_count"}, 32'(err_count), 32'(mErr));
    endtask

    // Called while clk is low; drives inputs, checks just after the edge, returns at the next negedge.
    task automatic applyStimulus(input logic [6:0] s, input logic r, input string tag);
        segment = s;
        out_ready = r;
        @(posedge clk);
        updateModel(s, r);
        #1 checkOutput(tag);
        @(negedge clk);
    endtask

    task automatic holdFor(input logic [6:0] s, input logic r, input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(s, r, tag);
    endtask

    initial begin
        resetModel();
        @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;

        $display("[TB] steady zero with consumer ready");
        holdFor(7'b1111110, 1'b1, 10, "zero_ready");

        $display("[TB] one held with consumer stalled, then accepted");
        holdFor(7'b0110000, 1'b0, 24, "one_stall");
        applyStimulus(7'b0110000, 1'b1, "one_accept");
        holdFor(7'b0110000, 1'b0, 2, "one_after");

        $display("[TB] short glitch back to last pattern");
        holdFor(7'b1111110, 1'b1, 8, "glitch_base");
        holdFor(7'b0110000, 1'b1, 2, "glitch");
        holdFor(7'b1111110, 1'b1, 8, "glitch_return");

        $display("[TB] illegal pattern");
        holdFor(7'b1010101, 1'b0, 8, "illegal");

        $display("[TB] overrun and simultaneous accept+load");
        holdFor(7'b0110000, 1'b0, 8, "pend_one");
        holdFor(7'b0000000, 1'b0, 6, "blank1");
        holdFor(7'b1111110, 1'b0, 8, "overrun");
        holdFor(7'b0000000, 1'b0, 6, "blank2");
        holdFor(7'b1111110, 1'b0, 4, "reload_wait");
        applyStimulus(7'b1111110, 1'b1, "reload");
        holdFor(7'b1111110, 1'b0, 3, "reload_hold");

        $display("[TB] asynchronous reset with a pending result");
        checkOne("valid_before_reset", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1 resetModel();
        checkOutput("async_reset");
        #1 rst_n = 1'b1;
        holdFor(7'b1111110, 1'b1, 8, "post_reset");

        $display("[TB] random patterns");
        for (int k = 0; k < 40; k++) begin
            logic [6:0] p;
            int kind, len;
            kind = $urandom_range(0, 4);
            case (kind)
                0: p = 7'b0000000;
                1: p = 7'b1111110;
                2: p = 7'b0110000;
                3: p = ($urandom_range(0, 1) != 0) ? 7'b0110000 : 7'b1111110;
                default: p = 7'($urandom);
            endcase
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++)
                applyStimulus(p, ($urandom_range(0, 3) == 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_to_bin.md
# seg_to_bin

Decoder for the two-symbol 7-segment display code: watches a 7-bit segment bus, waits for a stable pattern, and recovers the displayed bit. Only a pattern that differs from the last one evaluated is reported, through a valid/ready handshake. Sits on the display loopback path as a self-check of the XOR network's result display. Flags illegal patterns and handshake overruns, with an optional saturating error counter.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive samples a pattern must hold before evaluation; legal range 1..255.
- CNT_W, 8, width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- segment  input  7  segment bus, active-high, bit6=a … bit0=g.
- out_data  output  1  decoded bit.
- out_valid  output  1  out_data holds an unconsumed result.
- out_ready  input  1  consumer accepts when out_valid && out_ready at a clock edge.
- invalid  output  1  one-cycle pulse: a stable pattern is not a legal symbol.
- overrun  output  1  one-cycle pulse: a new result was dropped.
- err_count  output  CNT_W  saturating count of invalid and overrun pulses.

## Operation
- Symbol map:
  - 7'b1111110 -> 0.
  - 7'b0110000 -> 1.
  - 7'b0000000 = blank. It is a legal pattern and is never reported.
  - Every other value is illegal.
- segment is sampled into seg_q every cycle. Stability counter:
  - cleared when segment != seg_q;
  - otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - SETTLE: counting. When the count reaches STABLE_CYCLES, do one evaluation, then go to LOCKED.
  - LOCKED: hold. Any segment != seg_q returns the FSM to SETTLE with the count at 0.
- Evaluation of stable pattern P, with last_pat = the last pattern evaluated:
  - P == last_pat: no action.
  - P blank: last_pat <= P. No output.
  - P illegal: last_pat <= P. invalid pulses. out_valid and out_data unchanged.
  - P legal, and out_valid==0 or out_ready==1 this cycle: last_pat <= P, out_data <= symbol, out_valid <= 1.
  - P legal, out_valid==1 and out_ready==0: last_pat <= P, overrun pulses. The pending out_data is kept.
- Handshake:
  - out_valid falls on the accept edge unless a new result loads in the same cycle; in that case out_valid stays 1 and out_data takes the new value.
  - out_data is stable while out_valid is high.
- A glitch shorter than STABLE_CYCLES that returns to last_pat produces no report.

## Timing
- Reset values: out_data=0, out_valid=0, invalid=0, overrun=0, err_count=0. Internally: seg_q=0, count=0, last_pat=7'b0000000, FSM=SETTLE.
- Latency: a new pattern is present on segment before edge 1 and held constant. Then out_valid, invalid, or overrun is registered high after edge STABLE_CYCLES+1. Default: edge 5.
- invalid and overrun are each high for exactly one cycle per event.
- Reset asserted mid-operation: all state clears immediately, without waiting for clk. Any pending result is lost. The first stable legal pattern after release is reported, because last_pat is blank.
- Boundary: with STABLE_CYCLES=1, latency is 2 edges. A pattern toggling every cycle never leaves SETTLE.

## Configuration
- SEG_DEC_ERR_CNT_EN defined:
  - err_count increments by 1 on each cycle where invalid or overrun is high.
  - If both are high in one cycle, it increments by 1 only.
  - It saturates at 2^CNT_W-1 and is cleared only by reset.
- Not defined: err_count is tied to 0 and there is no counter logic. invalid and overrun behave identically in both builds.

## Test plan
- Reset then hold 7'b1111110, out_ready=1: out_valid pulses one cycle at edge 5 with out_data=0. Holding the pattern longer produces no further report.
- 7'b0110000 with out_ready=0: out_valid=1, out_data=1, held for 20 cycles. Then out_ready=1 for one cycle: out_valid=0 on the next edge.
- 7'b1111110 stable, then 7'b0110000 for 2 cycles, then back to 7'b1111110: no report, invalid=0.
- 7'b1010101 held: invalid pulses once at edge 5, out_valid stays 0. With the macro defined, err_count=1.
- Pending result out_data=1 with out_ready=0, then switch through blank to 7'b1111110: overrun pulses, out_data stays 1. Then drive out_valid=1, out_ready=1 with a new event in the same cycle: out_data updates and out_valid stays 1.
- Assert rst_n=0 asynchronously while out_valid=1: all outputs are 0 before the next clk edge.
